axi_wr_arbiter: RTL and testbench

Two-master to one-slave arbiter for AXI write transactions, placed between bench/BFM masters and the shared axi_slave write channels.
- Grants one complete write transaction (AW, all W beats, B) at a time; round-robin between masters.
- Tags the forwarded ID with the master index.
- Flags burst-length mismatches.

---
 rtl/axi_common_pkg.sv | 17 +
 rtl/axi_wr_arbiter.sv | 155 +++++++++++++++
 tb/tb_axi_wr_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_common_pkg.sv
// Shared definitions for the AXI write-path blocks.
// Write-arbiter FSM states and AXI response codes.
package axi_common;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam int NUM_M = 2;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/axi_wr_arbiter.sv
// Two-master to one-slave AXI write arbiter, one full
// transaction (AW, W burst, B) at a time, round-robin.
module axi_wr_arbiter
    import axi_common::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            m_awvalid,
    output logic [1:0]            m_awready,
    input  logic [2*ADDR_W-1:0]   m_awaddr,
    input  logic [2*ID_W-1:0]     m_awid,
    input  logic [15:0]           m_awlen,
    input  logic [1:0]            m_wvalid,
    output logic [1:0]            m_wready,
    input  logic [2*DATA_W-1:0]   m_wdata,
    input  logic [1:0]            m_wlast,
    output logic [1:0]            m_bvalid,
    input  logic [1:0]            m_bready,
    output logic [1:0]            m_bresp,
    output logic [ID_W-1:0]       m_bid,
    output logic                  s_awvalid,
    input  logic                  s_awready,
    output logic [ADDR_W-1:0]     s_awaddr,
    output logic [ID_W:0]         s_awid,
    output logic [7:0]            s_awlen,
    output logic                  s_wvalid,
    input  logic                  s_wready,
    output logic [DATA_W-1:0]     s_wdata,
    output logic                  s_wlast,
    input  logic                  s_bvalid,
    output logic                  s_bready,
    input  logic [1:0]            s_bresp,
    input  logic [ID_W:0]         s_bid,
    output logic                  len_err,
    output logic                  grant
);

    state_e     state_q, state_d;
    logic       prio_q, prio_d;
    logic       grant_q, grant_d;
    logic       err_q, err_d;
    logic [7:0] beat_q, beat_d;
    logic [7:0] len_q, len_d;

    logic       g;
    logic [1:0] g_oh;
    logic       wvalid_g;
    logic       wlast_g;
    logic       bready_g;
    logic       w_hs;
    logic       b_hs;

    assign g        = grant_q;
    assign g_oh     = g ? 2'b10 : 2'b01;
    assign wvalid_g = g ? m_wvalid[1] : m_wvalid[0];
    assign wlast_g  = g ? m_wlast[1]  : m_wlast[0];
    assign bready_g = g ? m_bready[1] : m_bready[0];

    assign w_hs = (state_q == DATA) && wvalid_g && s_wready;
    assign b_hs = (state_q == RESP) && s_bvalid && bready_g;

    // Datapath forwarding from the granted master and handshake gating.
    assign s_awvalid = (state_q == ADDR);
    assign s_awaddr  = g ? m_awaddr[2*ADDR_W-1:ADDR_W] : m_awaddr[ADDR_W-1:0];
    assign s_awid    = {g, (g ? m_awid[2*ID_W-1:ID_W] : m_awid[ID_W-1:0])};
    assign s_awlen   = g ? m_awlen[15:8] : m_awlen[7:0];
    assign m_awready = (s_awvalid && s_awready) ? g_oh : 2'b00;

    assign s_wvalid  = (state_q == DATA) && wvalid_g;
    assign s_wdata   = g ? m_wdata[2*DATA_W-1:DATA_W] : m_wdata[DATA_W-1:0];
    assign s_wlast   = wlast_g;
    assign m_wready  = ((state_q == DATA) && s_wready) ? g_oh : 2'b00;

    assign m_bvalid  = ((state_q == RESP) && s_bvalid) ? g_oh : 2'b00;
    assign s_bready  = (state_q == RESP) && bready_g;
    assign m_bresp   = s_bresp;
    assign m_bid     = s_bid[ID_W-1:0];

    assign len_err   = err_q;
    assign grant     = grant_q;

    // Next-state logic for arbitration, beat counting and error capture.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        grant_d = grant_q;
        err_d   = err_q;
        beat_d  = beat_q;
        len_d   = len_q;
        unique case (state_q)
            IDLE: begin
                if (|m_awvalid) begin
                    grant_d = m_awvalid[prio_q] ? prio_q : ~prio_q;
                    len_d   = grant_d ? m_awlen[15:8] : m_awlen[7:0];
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (s_awready) begin
                    beat_d  = 8'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (w_hs) begin
                    if (beat_q != 8'hFF) begin
                        beat_d = beat_q + 8'd1;
                    end
                    if (wlast_g) begin
                        if (beat_q != len_q) begin
                            err_d = 1'b1;
                        end
                        state_d = RESP;
                    end else if (beat_q == len_q) begin
                        err_d = 1'b1;
                    end
                end
            end
            RESP: begin
                if (b_hs) begin
                    prio_d  = ~grant_q;
                    state_d = IDLE;
                    if (s_bid[ID_W] != grant_q) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            grant_q <= 1'b0;
            err_q   <= 1'b0;
            beat_q  <= 8'd0;
            len_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            grant_q <= grant_d;
            err_q   <= err_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
        end
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: table of whole
// transactions plus hand-written reset and arbitration sequences.
module tb_axi_wr_arbiter;
    import axi_common::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      m_awvalid, m_awready;
    logic [2*AW-1:0] m_awaddr;
    logic [2*IW-1:0] m_awid;
    logic [15:0]     m_awlen;
    logic [1:0]      m_wvalid, m_wready;
    logic [2*DW-1:0] m_wdata;
    logic [1:0]      m_wlast;
    logic [1:0]      m_bvalid, m_bready;
    logic [1:0]      m_bresp;
    logic [IW-1:0]   m_bid;
    logic            s_awvalid, s_awready;
    logic [AW-1:0]   s_awaddr;
    logic [IW:0]     s_awid;
    logic [7:0]      s_awlen;
    logic            s_wvalid, s_wready;
    logic [DW-1:0]   s_wdata;
    logic            s_wlast;
    logic            s_bvalid, s_bready;
    logic [1:0]      s_bresp;
    logic [IW:0]     s_bid;
    logic            len_err, grant;

    always #5 clk = ~clk;

    axi_wr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awlen(m_awlen),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_wdata(m_wdata), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_bresp(m_bresp), .m_bid(m_bid),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_wdata(s_wdata), .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_bresp(s_bresp), .s_bid(s_bid),
        .len_err(len_err), .grant(grant)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         m;
        logic [3:0] id;
        logic [31:0] addr;
        logic [7:0] len;
        int         nb;
        bit         tog;
        bit         bad;
        logic [1:0] bresp;
        bit         err;
    } vec_t;

    vec_t v[4];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] wd(input int m, input int b);
        return 32'h0000_00A5 + 32'(m << 16) + 32'(b << 8);
    endfunction

    function automatic logic [1:0] oh(input int m);
        return (m == 1) ? 2'b10 : 2'b01;
    endfunction

    // Called at posedge+1 with the arbiter in IDLE; returns in DATA.
    task automatic start_aw(input int m, input logic [3:0] id,
                            input logic [31:0] addr, input logic [7:0] len);
        m_awaddr[m*AW +: AW] = addr;
        m_awid[m*IW +: IW]   = id;
        m_awlen[m*8 +: 8]    = len;
        m_awvalid[m]         = 1'b1;
        s_awready            = 1'b1;
        #1;
        chk("aw_idle_low", 64'(s_awvalid), 64'd0);
        @(posedge clk); #1;
        chk("aw_valid", 64'(s_awvalid), 64'd1);
        chk("aw_grant", 64'(grant), 64'(m));
        chk("aw_addr", 64'(s_awaddr), 64'(addr));
        chk("aw_id", 64'(s_awid), 64'({m[0], id}));
        chk("aw_len", 64'(s_awlen), 64'(len));
        chk("aw_ready", 64'(m_awready), 64'(oh(m)));
        @(posedge clk); #1;
        m_awvalid[m] = 1'b0;
        s_awready    = 1'b0;
    endtask

    task automatic send_beats(input int m, input int n, input bit tog,
                              input bit last);
        int b = 0;
        int cyc = 0;
        while (b < n && cyc < 64) begin
            m_wvalid[m]          = 1'b1;
            m_wdata[m*DW +: DW]  = wd(m, b);
            m_wlast[m]           = last && (b == n - 1);
            s_wready             = tog ? (cyc % 2 == 1) : 1'b1;
            #1;
            if (s_wready) begin
                chk("w_valid", 64'(s_wvalid), 64'd1);
                chk("w_data", 64'(s_wdata), 64'(wd(m, b)));
                chk("w_last", 64'(s_wlast), 64'(last && (b == n - 1)));
                chk("w_ready", 64'(m_wready), 64'(oh(m)));
                chk("w_grant", 64'(grant), 64'(m));
                b++;
            end else begin
                chk("w_stall", 64'(m_wready), 64'd0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        m_wvalid = 2'b00;
        m_wlast  = 2'b00;
        s_wready = 1'b0;
        if (b < n) chk("w_timeout", 64'(b), 64'(n));
    endtask

    task automatic resp(input int m, input logic [3:0] id, input bit bad,
                        input logic [1:0] br, input bit err);
        s_bvalid    = 1'b1;
        s_bid       = {(bad ? ~m[0] : m[0]), id};
        s_bresp     = br;
        m_bready[m] = 1'b1;
        #1;
        chk("b_valid", 64'(m_bvalid), 64'(oh(m)));
        chk("b_ready", 64'(s_bready), 64'd1);
        chk("b_id", 64'(m_bid), 64'(id));
        chk("b_resp", 64'(m_bresp), 64'(br));
        @(posedge clk); #1;
        s_bvalid = 1'b0;
        m_bready = 2'b00;
        #1;
        chk("b_done_idle", 64'(s_awvalid), 64'd0);
        chk("len_err", 64'(len_err), 64'(err));
    endtask

    task automatic run(input vec_t t);
        start_aw(t.m, t.id, t.addr, t.len);
        send_beats(t.m, t.nb, t.tog, 1'b1);
        resp(t.m, t.id, t.bad, t.bresp, t.err);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_aw"}, 64'({s_awvalid, m_awready}), 64'd0);
        chk({nm, "_w"}, 64'({s_wvalid, m_wready}), 64'd0);
        chk({nm, "_b"}, 64'({s_bready, m_bvalid}), 64'd0);
        chk({nm, "_grant"}, 64'(grant), 64'd0);
        chk({nm, "_err"}, 64'(len_err), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        v[0] = '{0, 4'h3, 32'h10,   8'd0, 1, 1'b0, 1'b0, OKAY,   1'b0};
        v[1] = '{1, 4'h7, 32'h200,  8'd3, 4, 1'b1, 1'b0, SLVERR, 1'b0};
        v[2] = '{0, 4'h5, 32'h300,  8'd3, 2, 1'b0, 1'b0, OKAY,   1'b1};
        v[3] = '{1, 4'h9, 32'h400,  8'd1, 2, 1'b0, 1'b0, OKAY,   1'b1};

        m_awvalid = '0; m_awaddr = '0; m_awid = '0; m_awlen = '0;
        m_wvalid = '0; m_wdata = '0; m_wlast = '0; m_bready = '0;
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
        s_bresp = '0; s_bid = '0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_quiet("reset");

        for (int i = 0; i < 4; i++) begin
            run(v[i]);
        end

        start_aw(0, 4'h1, 32'h500, 8'd3);
        send_beats(0, 2, 1'b0, 1'b0);
        m_wvalid[0] = 1'b1;
        s_wready    = 1'b1;
        pulse_rst();
        chk_quiet("mid_rst");
        m_wvalid = 2'b00;
        s_wready = 1'b0;

        run('{1, 4'hC, 32'h600, 8'd1, 2, 1'b0, 1'b0, OKAY, 1'b0});
        run('{1, 4'hD, 32'h700, 8'd0, 1, 1'b0, 1'b1, OKAY, 1'b1});

        pulse_rst();
        m_awaddr[AW +: AW] = 32'h800;
        m_awid[IW +: IW]   = 4'h2;
        m_awlen[15:8]      = 8'd0;
        m_awvalid[1]       = 1'b1;
        run('{0, 4'h4, 32'h900, 8'd0, 1, 1'b0, 1'b0, OKAY, 1'b0});
        run('{1, 4'h2, 32'h800, 8'd0, 1, 1'b0, 1'b0, OKAY, 1'b0});
        m_awvalid[1] = 1'b1;
        run('{0, 4'h6, 32'hA00, 8'd0, 1, 1'b0, 1'b0, OKAY, 1'b0});
        m_awvalid[1] = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
